// File: rtl/fp_add_result_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_result_buf_if
// Description : Issue/result/output bundle for fp_add_result_buf. out_flags
//               exists only when FP_RES_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_add_result_buf_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    res;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
`ifdef FP_RES_FLAGS_EN
    logic [2:0]       out_flags;

    modport master (
        output in_valid, res, out_ready,
        input  in_ready, out_data, out_valid, count, inflight, out_flags
    );
    modport slave (
        input  in_valid, res, out_ready,
        output in_ready, out_data, out_valid, count, inflight, out_flags
    );
`else
    modport master (
        output in_valid, res, out_ready,
        input  in_ready, out_data, out_valid, count, inflight
    );
    modport slave (
        input  in_valid, res, out_ready,
        output in_ready, out_data, out_valid, count, inflight
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fp_add_result_buf.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_result_buf
// Description : Result-capture FIFO behind a non-stallable pipelined FP adder,
//               with credit-based issue throttling. Define FP_RES_FLAGS_EN to
//               store and present {nan, inf, zero} flags per result.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_result_buf #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fp_add_result_buf_if.slave  bus
);
    localparam int DW = E_WIDTH + M_WIDTH + 1;
    localparam int PW = $clog2(DEPTH);
`ifdef FP_RES_FLAGS_EN
    localparam int SW = DW + 3;
`else
    localparam int SW = DW;
`endif

    logic               in_ready_w;
    logic               issue_w;
    logic               wr_en_w;
    logic               pop_w;
    logic [CNT_W:0]     credit_used_w;
    logic [CNT_W-1:0]   count_after_pop_w;
    logic [SW-1:0]      wr_word_w;

    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]      head_q, head_d;
    logic               out_valid_q, out_valid_d;
    logic [SW-1:0]      mem_q [DEPTH];

    // Credits cover both buffered and in-flight results, so a write can
    // never land on a full FIFO.
    assign credit_used_w = {1'b0, count_q} + {1'b0, inflight_q};
    assign in_ready_w    = !rst && (credit_used_w < (CNT_W+1)'(DEPTH));
    assign issue_w       = bus.in_valid && in_ready_w;
    assign wr_en_w       = vpipe_q[LATENCY-1];
    assign pop_w         = out_valid_q && bus.out_ready;

`ifdef FP_RES_FLAGS_EN
    logic [E_WIDTH-1:0] res_exp_w;
    logic [M_WIDTH-1:0] res_mnt_w;
    logic               exp_ones_w;
    logic               flag_nan_w;
    logic               flag_inf_w;
    logic               flag_zero_w;

    assign res_exp_w   = bus.res[DW-2:M_WIDTH];
    assign res_mnt_w   = bus.res[M_WIDTH-1:0];
    assign exp_ones_w  = &res_exp_w;
    assign flag_zero_w = (res_exp_w == '0) && (res_mnt_w == '0);
    assign flag_inf_w  = exp_ones_w && (res_mnt_w == '0);
    assign flag_nan_w  = exp_ones_w && (res_mnt_w != '0);
    assign wr_word_w   = {flag_nan_w, flag_inf_w, flag_zero_w, bus.res};
`else
    assign wr_word_w   = bus.res;
`endif

    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = issue_w;
        for (int k = 1; k < LATENCY; k++) begin
            vpipe_d[k] = vpipe_q[k-1];
        end

        inflight_d        = inflight_q + CNT_W'(issue_w) - CNT_W'(wr_en_w);
        count_d           = count_q + CNT_W'(wr_en_w) - CNT_W'(pop_w);
        count_after_pop_w = count_q - CNT_W'(pop_w);
        wr_ptr_d          = wr_ptr_q + PW'(wr_en_w);
        rd_ptr_d          = rd_ptr_q + PW'(pop_w);
        out_valid_d       = (count_d != '0);

        // The head register mirrors mem[rd_ptr]; when the FIFO would be empty
        // the incoming result goes straight to the head, one cycle late.
        head_d = head_q;
        if (wr_en_w && (count_after_pop_w == '0)) begin
            head_d = wr_word_w;
        end else if (pop_w && (count_after_pop_w != '0)) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q     <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            vpipe_q     <= vpipe_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en_w) begin
            mem_q[wr_ptr_q] <= wr_word_w;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_q[DW-1:0];
    assign bus.count     = count_q;
    assign bus.inflight  = inflight_q;
`ifdef FP_RES_FLAGS_EN
    assign bus.out_flags = head_q[SW-1:DW];
`endif

endmodule
`default_nettype wire
